// File: rtl/a2d_scan_seq.sv
// a2d_scan_seq
//   Autonomous scan sequencer sitting in front of A2D_intf. Every SCAN_PERIOD
//   clocks (while en is high) it walks the channels enabled in chnnl_mask from
//   0 to 7, issues one conversion per enabled channel and stores each 12-bit
//   result with a valid flag. Results are read back through a registered port.
//
// Ports
//   clk         system clock
//   rst_n       synchronous active-low reset
//   en          scan enable (gates new scan requests only)
//   chnnl_mask  bit i set = channel i is part of the scan
//   strt_cnv    one-cycle conversion start pulse to A2D_intf
//   chnnl       channel to convert, held from strt_cnv until completion
//   cnv_cmplt   completion strobe from A2D_intf
//   res         conversion result, valid with cnv_cmplt
//   rd_chnnl    read address
//   rd_res      stored result for rd_chnnl (1-cycle latency)
//   rd_vld      valid flag for rd_chnnl (1-cycle latency)
//   scan_done   one-cycle pulse at the end of each scan
//   err         sticky conversion timeout flag
//   clr_err     clears err (a simultaneous timeout wins)

module a2d_scan_seq #(
  parameter int SCAN_PERIOD = 1024,
  parameter int TIMEOUT     = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  chnnl_mask,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  input  logic [2:0]  rd_chnnl,
  output logic [11:0] rd_res,
  output logic        rd_vld,
  output logic        scan_done,
  output logic        err,
  input  logic        clr_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SELECT, START, WAIT, DONE} state_t;

  state_t        state;
  logic [15:0]   pcnt;
  logic          scan_req;
  logic [7:0]    mask_q;
  logic [2:0]    ptr;
  logic [TW-1:0] tcnt;
  logic [11:0]   result [8];
  logic [7:0]    vld;

  logic last_ch;
  logic timeout_hit;

  assign last_ch     = (ptr == 3'd7);
  assign timeout_hit = (tcnt == TW'(TIMEOUT - 1));

  // Period counter: parked at 0 while disabled so the first request lands in
  // the very cycle en is first seen high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (!en) begin
      pcnt <= '0;
    end else if (pcnt == 16'(SCAN_PERIOD - 1)) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 16'd1;
    end
  end

  // Scan state machine with its datapath. scan_req is a single pending bit,
  // so requests raised during a long scan collapse into one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      scan_req  <= 1'b0;
      mask_q    <= '0;
      ptr       <= '0;
      tcnt      <= '0;
      strt_cnv  <= 1'b0;
      chnnl     <= '0;
      scan_done <= 1'b0;
      err       <= 1'b0;
      vld       <= '0;
      for (int i = 0; i < 8; i++) begin
        result[i] <= '0;
      end
    end else begin
      strt_cnv  <= 1'b0;
      scan_done <= 1'b0;

      // A timeout in the same cycle overrides this clear below.
      if (clr_err) begin
        err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (scan_req) begin
            mask_q   <= chnnl_mask;
            scan_req <= 1'b0;
            ptr      <= '0;
            if (chnnl_mask != 8'd0) begin
              state <= SELECT;
            end
          end
        end

        // One cycle per skipped channel.
        SELECT: begin
          if (mask_q[ptr]) begin
            state    <= START;
            strt_cnv <= 1'b1;
            chnnl    <= ptr;
          end else if (last_ch) begin
            state     <= DONE;
            scan_done <= 1'b1;
          end else begin
            ptr <= ptr + 3'd1;
          end
        end

        START: begin
          tcnt  <= '0;
          state <= WAIT;
        end

        // Completion beats a timeout landing in the same cycle.
        WAIT: begin
          if (cnv_cmplt || timeout_hit) begin
            if (cnv_cmplt) begin
              result[ptr] <= res;
              vld[ptr]    <= 1'b1;
            end else begin
              err      <= 1'b1;
              vld[ptr] <= 1'b0;
            end
            if (last_ch) begin
              state     <= DONE;
              scan_done <= 1'b1;
            end else begin
              ptr   <= ptr + 3'd1;
              state <= SELECT;
            end
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase

      // A fresh request must survive an IDLE accept in the same cycle.
      if (en && (pcnt == 16'd0)) begin
        scan_req <= 1'b1;
      end
    end
  end

  // Registered read port; a same-cycle write shows up one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_res <= '0;
      rd_vld <= 1'b0;
    end else begin
      rd_res <= result[rd_chnnl];
      rd_vld <= vld[rd_chnnl];
    end
  end

endmodule
